// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for the shift-and-add multiplier.
// The master side drives start and the operands; the slave side is the multiplier.
interface shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one WIDTH-bit add and one right shift of {C,A,Q}
// per clock, giving a 2*WIDTH-bit product after WIDTH cycles in RUN.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     q_reg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product_reg;

  logic [WIDTH:0]       sum;
  logic                 carry;
  logic [WIDTH-1:0]     a_next;
  logic [WIDTH-1:0]     q_next;
  logic                 last_iter;

  // The carry C is consumed by the shift in the same edge that produces it and
  // always re-enters as 0, so it only needs to exist as the adder's carry-out.
  always_comb begin
    sum    = {1'b0, a_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
    carry  = sum[WIDTH];
    a_next = {carry, sum[WIDTH-1:1]};
    q_next = {sum[0], q_reg[WIDTH-1:1]};
  end

  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      cnt         <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_reg <= bus.multiplicand;
            q_reg <= bus.multiplier;
            a_reg <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            product_reg <= {a_next, q_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector bench for shift_add_multiplier (WIDTH=4) with hand-computed products.
module tb_shift_add_multiplier;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cycle++;
  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are driven #1 after a rising edge; the next rising edge is the accept edge.
  task automatic run_mul(input logic [3:0] m, input logic [3:0] q,
                         input logic [7:0] exp, input string tag);
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "/busy0"}, bus.busy, 1);
    check({tag, "/done0"}, bus.done, 0);
    for (int i = 1; i < int'(WIDTH); i++) begin
      tick();
      check({tag, "/busy"}, bus.busy, 1);
      check({tag, "/done_early"}, bus.done, 0);
    end
    tick();
    check({tag, "/done"}, bus.done, 1);
    check({tag, "/busy_in_done"}, bus.busy, 0);
    check({tag, "/product"}, bus.product, exp);
    tick();
    check({tag, "/done_cleared"}, bus.done, 0);
    check({tag, "/product_held"}, bus.product, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int c1;
    int c2;
    bit found;

    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #1;
    check("reset/busy", bus.busy, 0);
    check("reset/done", bus.done, 0);
    check("reset/product", bus.product, 8'h00);

    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle/busy", bus.busy, 0);
      check("idle/done", bus.done, 0);
      check("idle/product", bus.product, 8'h00);
    end

    run_mul(4'd13, 4'd6,  8'h4E, "13x6");
    run_mul(4'd15, 4'd15, 8'hE1, "15x15");
    run_mul(4'd0,  4'd15, 8'h00, "0x15");
    run_mul(4'd15, 4'd1,  8'h0F, "15x1");
    run_mul(4'd1,  4'd1,  8'h01, "1x1");

    // start ignored in RUN and DONE; operand changes during RUN have no effect
    bus.multiplicand = 4'd5;
    bus.multiplier   = 4'd3;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    d0 = done_seen;
    tick();
    bus.multiplicand = 4'd9;
    bus.multiplier   = 4'd9;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("ign/done", bus.done, 1);
    check("ign/product", bus.product, 8'h0F);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign/busy_after_done", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ign/no_reissue", bus.busy, 0);
    end
    check("ign/product_held", bus.product, 8'h0F);
    check("ign/one_done", done_seen - d0, 1);

    // asynchronous reset two cycles into RUN
    bus.multiplicand = 4'd14;
    bus.multiplier   = 4'd10;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("rst_mid/busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid/busy", bus.busy, 0);
    check("rst_mid/done", bus.done, 0);
    check("rst_mid/product", bus.product, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid/idle_busy", bus.busy, 0);
    check("rst_mid/idle_product", bus.product, 8'h00);
    run_mul(4'd14, 4'd10, 8'h8C, "14x10");

    // back-to-back issue with start held high
    bus.multiplicand = 4'd7;
    bus.multiplier   = 4'd9;
    bus.start        = 1'b1;
    tick();
    bus.multiplicand = 4'd12;
    bus.multiplier   = 4'd11;
    found = 1'b0;
    c1 = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        found = 1'b1;
        c1    = cycle;
      end
    end
    check("b2b/first_done_seen", found, 1);
    check("b2b/first_product", bus.product, 8'h3F);
    found = 1'b0;
    c2 = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        found = 1'b1;
        c2    = cycle;
      end else begin
        check("b2b/first_held", bus.product, 8'h3F);
      end
    end
    bus.start = 1'b0;
    check("b2b/second_done_seen", found, 1);
    check("b2b/interval", c2 - c1, 6);
    check("b2b/second_product", bus.product, 8'h84);
    tick();
    check("b2b/done_cleared", bus.done, 0);
    tick();
    check("b2b/stopped", bus.busy, 0);
    check("b2b/product_held", bus.product, 8'h84);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
